// File: rtl/pipe_pkg.sv
// Shared sizing helpers, legal parameter ranges and the buffer operation encoding
// used by pipe_stage_buf and its storage.
package pipe_pkg;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 512;
  localparam int unsigned DEPTH_MIN = 1;
  localparam int unsigned DEPTH_MAX = 8;

  // Per-cycle buffer operation, packed as {push, pop}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } buf_op_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic in_range(input int unsigned v, input int unsigned lo,
                                    input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// DEPTH x WIDTH register storage: one write port, one asynchronous read port,
// synchronous clear and asynchronous clear on resetn.
module pipe_buf_mem
  import pipe_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Circular-buffer pipeline stage with flush and stall.
// Define PIPE_STAGE_BYPASS_EN for zero-latency fall-through when the buffer is empty.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned      PTR_W    = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  if (!in_range(WIDTH, WIDTH_MIN, WIDTH_MAX)) begin : g_bad_width
    $error("pipe_stage_buf: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end
  if (!in_range(DEPTH, DEPTH_MIN, DEPTH_MAX)) begin : g_bad_depth
    $error("pipe_stage_buf: DEPTH=%0d outside %0d..%0d", DEPTH, DEPTH_MIN, DEPTH_MAX);
  end

  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata;
  logic             empty, full, bypass, push, pop;
  buf_op_e          op;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_FULL);
  assign in_ready = ~stall & ~full;
  assign count    = cnt_q;

`ifdef PIPE_STAGE_BYPASS_EN
  assign bypass = empty & ~stall & ~flush & in_valid;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    out_valid = bypass | (~stall & ~empty);
    out_data  = '0;
    if (bypass) begin
      out_data = in_data;
    end else if (out_valid) begin
      out_data = rdata;
    end
  end

  // A fall-through word taken downstream is never stored; the empty buffer is never popped.
  assign push = in_valid & in_ready & ~flush & ~(bypass & out_ready);
  assign pop  = out_valid & out_ready & ~flush & ~bypass;
  assign op   = buf_op_e'({push, pop});

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = ptr_inc(wptr_q);
    if (pop)  rptr_d = ptr_inc(rptr_q);
    case (op)
      OP_PUSH: cnt_d = cnt_q + 1'b1;
      OP_POP:  cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (flush) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  pipe_buf_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk   (clk),
    .resetn(resetn),
    .clr   (flush),
    .we    (push),
    .waddr (wptr_q),
    .wdata (in_data),
    .raddr (rptr_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Checks DEPTH=2 and DEPTH=3 instances, driven in lockstep, against a
// push/pop history model; directed scenarios first, then random traffic.
module tb_pipe_stage_buf;

  localparam int unsigned W    = 32;
  localparam int unsigned HIST = 4096;
`ifdef PIPE_STAGE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn, flush, stall, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic [1:0]        o_rdy, o_vld;
  logic [1:0][W-1:0] o_dat;
  logic [1:0][1:0]   o_cnt;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(W), .DEPTH(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(o_rdy[0]), .in_data(in_data),
    .out_valid(o_vld[0]), .out_ready(out_ready), .out_data(o_dat[0]),
    .count(o_cnt[0])
  );

  pipe_stage_buf #(.WIDTH(W), .DEPTH(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(o_rdy[1]), .in_data(in_data),
    .out_valid(o_vld[1]), .out_ready(out_ready), .out_data(o_dat[1]),
    .count(o_cnt[1])
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference: every accepted word in arrival order; occupancy = pushed - popped.
  logic [W-1:0] hist [2][HIST];
  int unsigned  push_n [2];
  int unsigned  pop_n  [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int unsigned depth_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int unsigned occ(input int k);
    return push_n[k] - pop_n[k];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) pop_n[k] = push_n[k];
  endtask

  task automatic step(input logic st, input logic fl, input logic iv,
                      input logic [W-1:0] d, input logic ordy);
    logic e_rdy, e_vld, e_byp;
    logic [W-1:0] e_dat;
    @(negedge clk);
    stall = st; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    for (int k = 0; k < 2; k++) begin
      e_rdy = !st && (occ(k) != depth_of(k));
      e_byp = BYP && (occ(k) == 0) && !st && !fl && iv;
      e_vld = e_byp || (!st && occ(k) != 0);
      e_dat = e_byp ? d : (e_vld ? hist[k][pop_n[k] % HIST] : '0);
      check($sformatf("d%0d.in_ready", depth_of(k)),  64'(o_rdy[k]), 64'(e_rdy));
      check($sformatf("d%0d.out_valid", depth_of(k)), 64'(o_vld[k]), 64'(e_vld));
      check($sformatf("d%0d.out_data", depth_of(k)),  64'(o_dat[k]), 64'(e_dat));
      check($sformatf("d%0d.count", depth_of(k)),     64'(o_cnt[k]), 64'(occ(k)));
      if (fl) begin
        pop_n[k] = push_n[k];
      end else if (e_byp) begin
        if (!ordy) begin
          hist[k][push_n[k] % HIST] = d;
          push_n[k]++;
        end
      end else begin
        if (e_vld && ordy) pop_n[k]++;
        if (iv && e_rdy) begin
          hist[k][push_n[k] % HIST] = d;
          push_n[k]++;
        end
      end
    end
    @(posedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      push_n[k] = 0;
      pop_n[k]  = 0;
    end
    resetn = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_data = '0;
    #12;
    check("rst.in_ready",  64'(o_rdy), 64'(2'b11));
    check("rst.out_valid", 64'(o_vld), 64'(2'b00));
    check("rst.out_data0", 64'(o_dat[0]), 64'(0));
    check("rst.count",     64'({o_cnt[1], o_cnt[0]}), 64'(0));
    stall = 1'b1;
    #1;
    check("rst.stall_in_ready", 64'(o_rdy), 64'(2'b00));
    @(negedge clk);
    resetn = 1'b1;
    stall  = 1'b0;

    // Fill DEPTH=2 to full, then drain in order.
    step(0, 0, 1, 32'hA, 0);
    step(0, 0, 1, 32'hB, 0);
    step(0, 0, 1, 32'hC, 0);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 1, 0, 32'h0, 0);

    // Continuous streaming through the wrap points.
    for (int unsigned i = 1; i <= 10; i++) step(0, 0, 1, W'(i), 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 1, 0, 32'h0, 0);

    // Flush while full with a competing input word.
    step(0, 0, 1, 32'h11, 0);
    step(0, 0, 1, 32'h22, 0);
    step(0, 1, 1, 32'h55, 1);
    step(0, 0, 0, 32'h0, 0);
    check("flush.count", 64'(o_cnt[0]), 64'(0));
    step(0, 0, 0, 32'h0, 1);

    // Stall holds a single entry, then releases it.
    step(0, 0, 1, 32'h3C, 0);
    for (int unsigned i = 0; i < 3; i++) step(1, 0, 1, 32'hFF, 1);
    step(0, 0, 0, 32'h0, 1);
    step(1, 1, 1, 32'h99, 1);
    step(0, 0, 0, 32'h0, 1);

    // Asynchronous reset in the middle of a cycle.
    step(0, 0, 1, 32'h1234, 0);
    step(0, 0, 1, 32'h5678, 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("arst.count",     64'({o_cnt[1], o_cnt[0]}), 64'(0));
    check("arst.out_valid", 64'(o_vld), 64'(2'b00));
    check("arst.out_data",  64'(o_dat[0]), 64'(0));
    model_clear();
    @(negedge clk);
    resetn = 1'b1;

    // Empty buffer offered a word that downstream takes immediately.
    step(0, 0, 1, 32'h77, 1);
    step(0, 0, 0, 32'h0, 1);

    for (int unsigned i = 0; i < 1200; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
